alu_seq: RTL

- Parametrised, registered successor to the datapath's 16-bit combinational ALU.
- Arithmetic, logic, shift and rotate ops complete in one cycle; signed multiply runs as an iterative radix-4 Booth unit.
- Status flags are produced with every result.
- Sits between the register-file read stage and write-back, with valid/ready handshakes on both sides so the multiply can stall the pipeline.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle arithmetic/logic/shift/rotate ops
// and an iterative radix-4 Booth multiplier, behind valid/ready handshakes.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_next;
  logic   accept;

  // Single-cycle datapath signals
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     inv_amt;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout, alu_ovf, alu_err;

  // Booth multiplier state
  logic [2*WIDTH-1:0] mcand, acc, term, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic               mprev;
  logic [CW-1:0]      cnt;
  logic               mul_ovf;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // Combinational result and flags for every one-cycle opcode
  always_comb begin
    amt      = i1[SHW-1:0];
    inv_amt  = (SHW+1)'(WIDTH) - {1'b0, amt};
    sum      = {1'b0, i0} + {1'b0, i1};
    diff     = {1'b0, i0} + {1'b0, ~i1} + {{WIDTH{1'b0}}, 1'b1};
    alu_o    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_err  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_o    = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (i0[WIDTH-1] == i1[WIDTH-1]) && (sum[WIDTH-1] != i0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_o    = diff[WIDTH-1:0];
        alu_cout = diff[WIDTH];
        alu_ovf  = (i0[WIDTH-1] != i1[WIDTH-1]) && (diff[WIDTH-1] != i0[WIDTH-1]);
      end
      OP_AND: alu_o = i0 & i1;
      OP_OR:  alu_o = i0 | i1;
      OP_XOR: alu_o = i0 ^ i1;
      OP_MUL: alu_o = '0;
      OP_SHL: alu_o = i0 << amt;
      OP_SHR: alu_o = i0 >> amt;
      OP_SRA: alu_o = $signed(i0) >>> amt;
      // amount 0 gives inv_amt == WIDTH, so the wrapped half shifts out to zero
      OP_ROL: alu_o = (i0 << amt) | (i0 >> inv_amt);
      OP_ROR: alu_o = (i0 >> amt) | (i0 << inv_amt);
      default: alu_err = 1'b1;
    endcase
  end

  // Booth digit recoding: add 0, +/-1 or +/-2 times the aligned multiplicand
  always_comb begin
    term = '0;
    case ({mplier[1:0], mprev})
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = '0 - (mcand << 1);
      3'b101, 3'b110: term = '0 - mcand;
      default:        term = '0;
    endcase
    acc_next = acc + term;
    mul_ovf  = acc_next[2*WIDTH-1:WIDTH] != {WIDTH{acc_next[WIDTH-1]}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a release in DONE may be paired with a new accept
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (op == OP_MUL) ? MUL : DONE;
      MUL:  if (cnt == LAST) state_next = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_next = (op == OP_MUL) ? MUL : DONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result/flag registers and multiplier iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o      <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      mprev  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= {{WIDTH{i0[WIDTH-1]}}, i0};
        mplier <= i1;
        mprev  <= 1'b0;
        acc    <= '0;
        cnt    <= '0;
        err    <= 1'b0;
      end else begin
        o    <= alu_o;
        cout <= alu_cout;
        ovf  <= alu_ovf;
        err  <= alu_err;
        zero <= (alu_o == '0);
        neg  <= alu_o[WIDTH-1];
      end
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 2;
      mplier <= mplier >> 2;
      mprev  <= mplier[1];
      cnt    <= cnt + 1'b1;
      // The last digit's sum is written straight into the result registers
      if (cnt == LAST) begin
        o    <= acc_next[WIDTH-1:0];
        cout <= 1'b0;
        ovf  <= mul_ovf;
        err  <= 1'b0;
        zero <= (acc_next[WIDTH-1:0] == '0);
        neg  <= acc_next[WIDTH-1];
      end
    end
  end

endmodule
